// File: rtl/shifttilebuffer_var_pkg.sv
// Shared constants, entry type and depth helpers for the shift-read tile buffer.
package cutie_tilebuffer_pkg;

    localparam int unsigned N_I_DEF       = 256;
    localparam int unsigned DATA_W_DEF    = 2;
    localparam int unsigned MAX_DEPTH_DEF = 5;

    // Width able to hold every depth value 0..max_depth.
    function automatic int unsigned calc_depth_w(input int unsigned max_depth);
        return $clog2(max_depth + 1);
    endfunction

    // Write-pointer width; never narrower than one bit.
    function automatic int unsigned calc_ptr_w(input int unsigned max_depth);
        return (max_depth > 1) ? $clog2(max_depth) : 1;
    endfunction

    localparam int unsigned DEPTH_W = calc_depth_w(MAX_DEPTH_DEF);
    localparam int unsigned PTR_W   = calc_ptr_w(MAX_DEPTH_DEF);

    typedef logic [0:N_I_DEF-1][DATA_W_DEF-1:0] entry_t;

    // A zero depth would leave no window; oversize requests fall back to the physical size.
    function automatic int unsigned clamp_depth(input int unsigned depth,
                                                input int unsigned max_depth);
        if (depth == 0)        return 1;
        if (depth > max_depth) return max_depth;
        return depth;
    endfunction

endpackage

// File: rtl/shifttilebuffer_var_modptr.sv
// Write pointer that wraps at a run-time bound, plus a fill count saturating at that bound.
module tilebuffer_modptr #(
    parameter int unsigned PTR_W   = 3,
    parameter int unsigned DEPTH_W = 3
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               inc_i,
    input  logic               clr_i,
    input  logic [DEPTH_W-1:0] bound_i,
    output logic [PTR_W-1:0]   ptr_o,
    output logic [DEPTH_W-1:0] fill_o
);

    logic [PTR_W-1:0]   r_ptr;
    logic [DEPTH_W-1:0] r_fill;
    logic               w_last;

    // Pointer sits on the last slot of the active window.
    assign w_last = (DEPTH_W'(r_ptr) == (bound_i - DEPTH_W'(1)));

    // Pointer and fill: clear wins over increment; otherwise hold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr  <= '0;
            r_fill <= '0;
        end else if (clr_i) begin
            r_ptr  <= '0;
            r_fill <= '0;
        end else if (inc_i) begin
            // NOTE: non-blocking so both registers see the pre-edge values of each other.
            r_ptr  <= w_last ? '0 : r_ptr + PTR_W'(1);
            r_fill <= (r_fill < bound_i) ? r_fill + DEPTH_W'(1) : bound_i;
        end
    end

    assign ptr_o  = r_ptr;
    assign fill_o = r_fill;

endmodule

// File: rtl/shifttilebuffer_var.sv
// FIFO-written, shift-register-read window memory with run-time depth and zero-pad insertion.
module shifttilebuffer_var
    import cutie_tilebuffer_pkg::*;
#(
    parameter  int unsigned N_I       = 256,
    parameter  int unsigned DATA_W    = 2,
    parameter  int unsigned MAX_DEPTH = 5,
    localparam int unsigned P_DEPTH_W = calc_depth_w(MAX_DEPTH),
    localparam int unsigned P_PTR_W   = calc_ptr_w(MAX_DEPTH)
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic [0:N_I-1][DATA_W-1:0]                  data_i,
    input  logic                                        push_i,
    input  logic                                        pad_i,
    input  logic                                        flush_i,
    input  logic [P_DEPTH_W-1:0]                        depth_i,
    output logic [0:MAX_DEPTH-1][0:N_I-1][DATA_W-1:0]   data_o,
    output logic                                        valid_o,
    output logic [P_DEPTH_W-1:0]                        fill_o,
    output logic [P_DEPTH_W-1:0]                        depth_o
);

    localparam int unsigned SUM_W = P_DEPTH_W + 1;

    logic [0:N_I-1][DATA_W-1:0] r_mem [MAX_DEPTH];
    logic [P_DEPTH_W-1:0]       r_depth;
    logic [P_PTR_W-1:0]         w_ptr;
    logic [P_DEPTH_W-1:0]       w_fill;
    logic                       w_push;

    assign w_push = push_i & ~flush_i;

    tilebuffer_modptr #(
        .PTR_W   (P_PTR_W),
        .DEPTH_W (P_DEPTH_W)
    ) u_modptr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (w_push),
        .clr_i   (flush_i),
        .bound_i (r_depth),
        .ptr_o   (w_ptr),
        .fill_o  (w_fill)
    );

    // Storage and active depth: flush clears and latches depth, push writes one entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: storage is reset because empty-window reads must show zeros, not stale data.
            r_mem   <= '{default: '0};
            r_depth <= P_DEPTH_W'(MAX_DEPTH);
        end else if (flush_i) begin
            r_mem   <= '{default: '0};
            r_depth <= P_DEPTH_W'(clamp_depth(32'(depth_i), MAX_DEPTH));
        end else if (push_i) begin
            r_mem[w_ptr] <= pad_i ? '0 : data_i;
        end
    end

    // Window read: slot i shows the entry i positions after the oldest, modulo depth.
    for (genvar i = 0; i < MAX_DEPTH; i++) begin : g_slot
        localparam logic [SUM_W-1:0] SLOT = SUM_W'(i);
        logic [SUM_W-1:0] w_sum;
        logic [SUM_W-1:0] w_idx;

        assign w_sum     = SUM_W'(w_ptr) + SLOT;
        assign w_idx     = (w_sum >= SUM_W'(r_depth)) ? w_sum - SUM_W'(r_depth) : w_sum;
        assign data_o[i] = (SLOT < SUM_W'(r_depth)) ? r_mem[w_idx] : '0;
    end

    assign valid_o = (w_fill == r_depth);
    assign fill_o  = w_fill;
    assign depth_o = r_depth;

endmodule

// File: tb/tb_shifttilebuffer_var.sv
// Directed self-checking bench for shifttilebuffer_var (N_I=4, DATA_W=2, MAX_DEPTH=5).
module tb_shifttilebuffer_var;

    localparam int unsigned N_I       = 4;
    localparam int unsigned DATA_W    = 2;
    localparam int unsigned MAX_DEPTH = 5;
    localparam int unsigned DW        = 3;

    logic                                       clk_i;
    logic                                       rst_ni;
    logic [0:N_I-1][DATA_W-1:0]                 data_i;
    logic                                       push_i;
    logic                                       pad_i;
    logic                                       flush_i;
    logic [DW-1:0]                              depth_i;
    logic [0:MAX_DEPTH-1][0:N_I-1][DATA_W-1:0]  data_o;
    logic                                       valid_o;
    logic [DW-1:0]                              fill_o;
    logic [DW-1:0]                              depth_o;

    int total = 0;
    int bad   = 0;

    typedef logic [7:0] ent_t;
    ent_t exp_win [MAX_DEPTH];

    localparam ent_t A = 8'h1B, B = 8'h2C, C = 8'h39, D = 8'h4E;
    localparam ent_t E = 8'h63, F = 8'h78, G = 8'hD2, P = 8'h91;
    localparam ent_t Q = 8'hA4, R = 8'hC6;

    shifttilebuffer_var #(
        .N_I       (N_I),
        .DATA_W    (DATA_W),
        .MAX_DEPTH (MAX_DEPTH)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .data_i  (data_i),
        .push_i  (push_i),
        .pad_i   (pad_i),
        .flush_i (flush_i),
        .depth_i (depth_i),
        .data_o  (data_o),
        .valid_o (valid_o),
        .fill_o  (fill_o),
        .depth_o (depth_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // One clock cycle with the given controls; outputs are settled 1 ns after the edge.
    task automatic cycle(input logic push, input logic pad, input logic flush,
                         input logic [DW-1:0] depth, input ent_t data);
        @(negedge clk_i);
        push_i  = push;
        pad_i   = pad;
        flush_i = flush;
        depth_i = depth;
        data_i  = data;
        @(posedge clk_i);
        #1;
        push_i  = 1'b0;
        pad_i   = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        push_i = 1'b0; pad_i = 1'b0; flush_i = 1'b0; depth_i = '0; data_i = '0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        total++; if (data_o !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", data_o); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid_o); end
        total++; if (fill_o !== 3'd0) begin bad++; $display("FAIL reset_fill got=%0d want=0", fill_o); end
        total++; if (depth_o !== 3'd5) begin bad++; $display("FAIL reset_depth got=%0d want=5", depth_o); end
    endtask

    task automatic test_fill_depth3();
        cycle(1'b0, 1'b0, 1'b1, 3'd3, 8'h00);
        total++; if (depth_o !== 3'd3) begin bad++; $display("FAIL fill_depth got=%0d want=3", depth_o); end
        cycle(1'b1, 1'b0, 1'b0, 3'd3, A);
        total++; if (fill_o !== 3'd1 || valid_o !== 1'b0) begin bad++; $display("FAIL fill_a got=%0d/%b want=1/0", fill_o, valid_o); end
        total++; if (data_o[2] !== A || data_o[0] !== '0) begin bad++; $display("FAIL win_a got=%h want slot2=%h", data_o, A); end
        cycle(1'b1, 1'b0, 1'b0, 3'd3, B);
        total++; if (fill_o !== 3'd2 || valid_o !== 1'b0) begin bad++; $display("FAIL fill_b got=%0d/%b want=2/0", fill_o, valid_o); end
        cycle(1'b1, 1'b0, 1'b0, 3'd3, C);
        total++; if (fill_o !== 3'd3 || valid_o !== 1'b1) begin bad++; $display("FAIL fill_c got=%0d/%b want=3/1", fill_o, valid_o); end
        exp_win = '{A, B, C, 8'h00, 8'h00};
        for (int i = 0; i < MAX_DEPTH; i++) begin
            total++;
            if (data_o[i] !== exp_win[i]) begin bad++; $display("FAIL win_abc[%0d] got=%h want=%h", i, data_o[i], exp_win[i]); end
        end
    endtask

    task automatic test_wrap();
        cycle(1'b1, 1'b0, 1'b0, 3'd3, D);
        cycle(1'b1, 1'b0, 1'b0, 3'd3, E);
        total++; if (valid_o !== 1'b1 || fill_o !== 3'd3) begin bad++; $display("FAIL wrap_valid got=%b/%0d want=1/3", valid_o, fill_o); end
        exp_win = '{C, D, E, 8'h00, 8'h00};
        for (int i = 0; i < MAX_DEPTH; i++) begin
            total++;
            if (data_o[i] !== exp_win[i]) begin bad++; $display("FAIL win_cde[%0d] got=%h want=%h", i, data_o[i], exp_win[i]); end
        end
    endtask

    task automatic test_pad();
        cycle(1'b0, 1'b0, 1'b1, 3'd3, 8'h00);
        total++; if (data_o !== '0 || fill_o !== 3'd0) begin bad++; $display("FAIL pad_flush got=%h/%0d want=0/0", data_o, fill_o); end
        cycle(1'b1, 1'b0, 1'b0, 3'd3, A);
        cycle(1'b1, 1'b1, 1'b0, 3'd3, 8'hFF);
        exp_win = '{8'h00, A, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < MAX_DEPTH; i++) begin
            total++;
            if (data_o[i] !== exp_win[i]) begin bad++; $display("FAIL win_a0[%0d] got=%h want=%h", i, data_o[i], exp_win[i]); end
        end
        cycle(1'b1, 1'b0, 1'b0, 3'd3, C);
        exp_win = '{A, 8'h00, C, 8'h00, 8'h00};
        for (int i = 0; i < MAX_DEPTH; i++) begin
            total++;
            if (data_o[i] !== exp_win[i]) begin bad++; $display("FAIL win_a0c[%0d] got=%h want=%h", i, data_o[i], exp_win[i]); end
        end
        total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL pad_valid got=%b want=1", valid_o); end
    endtask

    task automatic test_flush_priority();
        cycle(1'b1, 1'b0, 1'b1, 3'd0, G);
        total++; if (depth_o !== 3'd1) begin bad++; $display("FAIL prio_depth got=%0d want=1", depth_o); end
        total++; if (fill_o !== 3'd0 || valid_o !== 1'b0) begin bad++; $display("FAIL prio_fill got=%0d/%b want=0/0", fill_o, valid_o); end
        total++; if (data_o !== '0) begin bad++; $display("FAIL prio_data got=%h want=0", data_o); end
        cycle(1'b1, 1'b0, 1'b0, 3'd0, F);
        total++; if (data_o[0] !== F || valid_o !== 1'b1) begin bad++; $display("FAIL d1_f got=%h/%b want=%h/1", data_o[0], valid_o, F); end
        cycle(1'b1, 1'b0, 1'b0, 3'd0, G);
        total++; if (data_o[0] !== G || fill_o !== 3'd1) begin bad++; $display("FAIL d1_g got=%h/%0d want=%h/1", data_o[0], fill_o, G); end
        total++; if (data_o[1:4] !== '0) begin bad++; $display("FAIL d1_tail got=%h want=0", data_o[1:4]); end
    endtask

    task automatic test_clamp_and_reset();
        cycle(1'b0, 1'b0, 1'b1, 3'd7, 8'h00);
        total++; if (depth_o !== 3'd5) begin bad++; $display("FAIL clamp_hi got=%0d want=5", depth_o); end
        cycle(1'b1, 1'b0, 1'b0, 3'd2, P);
        cycle(1'b1, 1'b0, 1'b0, 3'd2, Q);
        cycle(1'b1, 1'b0, 1'b0, 3'd2, R);
        total++; if (depth_o !== 3'd5 || fill_o !== 3'd3) begin bad++; $display("FAIL no_flush_depth got=%0d/%0d want=5/3", depth_o, fill_o); end
        exp_win = '{8'h00, 8'h00, P, Q, R};
        for (int i = 0; i < MAX_DEPTH; i++) begin
            total++;
            if (data_o[i] !== exp_win[i]) begin bad++; $display("FAIL win_pqr[%0d] got=%h want=%h", i, data_o[i], exp_win[i]); end
        end
        // Reset between clock edges: outputs must clear with no edge.
        @(negedge clk_i);
        #2;
        push_i = 1'b1;
        rst_ni = 1'b0;
        #1;
        total++; if (data_o !== '0) begin bad++; $display("FAIL async_data got=%h want=0", data_o); end
        total++; if (valid_o !== 1'b0 || fill_o !== 3'd0) begin bad++; $display("FAIL async_fill got=%b/%0d want=0/0", valid_o, fill_o); end
        total++; if (depth_o !== 3'd5) begin bad++; $display("FAIL async_depth got=%0d want=5", depth_o); end
        @(negedge clk_i);
        push_i = 1'b0;
        rst_ni = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fill_depth3();
        test_wrap();
        test_pad();
        test_flush_priority();
        test_clamp_and_reset();
        repeat (2) @(posedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
